// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: packs a 32-bit plaintext stream into 512-bit blocks for
// chacha_core, issues init/next pulses, waits for the core result with a
// timeout, and serialises the result back out as 32-bit words.
// Build macro CHACHA_STREAM_STATS_EN adds the stat_blocks/stat_cycles counters.
module chacha_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [63:0]  iv_in,
  input  logic [63:0]  ctr_in,
  input  logic [31:0]  s_word,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [31:0]  m_word,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic [63:0]  core_iv,
  output logic [63:0]  core_ctr,
  output logic [511:0] core_data_in,
  input  logic         core_ready,
  input  logic [511:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         busy,
  output logic         error
`ifdef CHACHA_STREAM_STATS_EN
  ,
  output logic [31:0]  stat_blocks,
  output logic [31:0]  stat_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DRAIN, S_ERR} state_t;

  state_t            state_reg, state_next;
  logic [255:0]      key_reg;
  logic [63:0]       iv_reg, ctr_reg;
  logic [31:0]       blk_reg  [16];
  logic [31:0]       blk_next [16];
  logic [31:0]       cap_reg  [16];
  logic [3:0]        wcnt_reg, ocnt_reg;
  logic [4:0]        nwords_reg;
  logic              first_reg, last_msg_reg, error_reg;
  logic [TO_W-1:0]   to_cnt_reg;

  logic take_start, accept, closing, capture, timeout, out_final, out_fire, pulse;

  // start is only honoured when not busy (IDLE, or ERR to recover)
  assign take_start = start && (state_reg == S_IDLE || state_reg == S_ERR);
  assign accept     = (state_reg == S_FILL) && s_valid;
  assign closing    = accept && (wcnt_reg == 4'd15 || s_last);
  assign capture    = (state_reg == S_WAIT) && core_data_out_valid;
  assign timeout    = (state_reg == S_WAIT) && !core_data_out_valid &&
                      (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign out_final  = ({1'b0, ocnt_reg} == nwords_reg - 5'd1);
  assign out_fire   = (state_reg == S_DRAIN) && m_ready;
  assign pulse      = core_init || core_next;

  assign core_key = key_reg;
  assign core_iv  = iv_reg;
  assign core_ctr = ctr_reg;
  assign error    = error_reg;
  assign m_word   = cap_reg[ocnt_reg];

  // word 0 of the block sits in the most significant slot
  for (genvar gi = 0; gi < 16; gi++) begin : g_pack
    assign core_data_in[511 - 32*gi -: 32] = blk_reg[gi];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake/pulse outputs
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      S_IDLE: if (take_start) state_next = S_FILL;
      S_FILL: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (closing) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (core_ready) begin
          core_init  = first_reg;
          core_next  = !first_reg;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (capture)      state_next = S_DRAIN;
        else if (timeout) state_next = S_ERR;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = last_msg_reg && out_final;
        if (out_fire && out_final) state_next = last_msg_reg ? S_IDLE : S_FILL;
      end
      S_ERR: if (take_start) state_next = S_FILL;
      default: state_next = S_IDLE;
    endcase
  end

  // Block assembly: write the accepted slot, zero the unused tail on close
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      blk_next[k] = blk_reg[k];
      if (accept && wcnt_reg == 4'(k))        blk_next[k] = s_word;
      else if (closing && 4'(k) > wcnt_reg)   blk_next[k] = '0;
    end
  end

  // Datapath registers: message parameters, counters, capture, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg      <= '0;
      iv_reg       <= '0;
      ctr_reg      <= '0;
      wcnt_reg     <= '0;
      ocnt_reg     <= '0;
      nwords_reg   <= '0;
      first_reg    <= 1'b1;
      last_msg_reg <= 1'b0;
      error_reg    <= 1'b0;
      to_cnt_reg   <= '0;
      for (int k = 0; k < 16; k++) begin
        blk_reg[k] <= '0;
        cap_reg[k] <= '0;
      end
    end else begin
      if (take_start) begin
        key_reg    <= key_in;
        iv_reg     <= iv_in;
        ctr_reg    <= ctr_in;
        first_reg  <= 1'b1;
        error_reg  <= 1'b0;
        wcnt_reg   <= '0;
        ocnt_reg   <= '0;
        to_cnt_reg <= '0;
      end
      for (int k = 0; k < 16; k++) blk_reg[k] <= blk_next[k];
      if (accept) begin
        wcnt_reg <= wcnt_reg + 4'd1;
        if (closing) begin
          nwords_reg   <= {1'b0, wcnt_reg} + 5'd1;
          last_msg_reg <= s_last;
        end
      end
      if (pulse) begin
        first_reg  <= 1'b0;
        to_cnt_reg <= '0;
      end
      if (capture) begin
        for (int k = 0; k < 16; k++) cap_reg[k] <= core_data_out[511 - 32*k -: 32];
        to_cnt_reg <= '0;
      end else if (timeout) begin
        error_reg <= 1'b1;
      end else if (state_reg == S_WAIT) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (out_fire) begin
        if (out_final) begin
          ocnt_reg <= '0;
          if (!last_msg_reg) wcnt_reg <= '0;
        end else begin
          ocnt_reg <= ocnt_reg + 4'd1;
        end
      end
    end
  end

`ifdef CHACHA_STREAM_STATS_EN
  // Saturating statistics: core pulses issued and cycles spent waiting
  always_ff @(posedge clk) begin
    if (rst || take_start) begin
      stat_blocks <= '0;
      stat_cycles <= '0;
    end else begin
      if (pulse && stat_blocks != '1)                   stat_blocks <= stat_blocks + 32'd1;
      if (state_reg == S_WAIT && stat_cycles != '1)     stat_cycles <= stat_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/chacha_stream_ctrl.md
Name: chacha_stream_ctrl

Overview:
Upstream sequencer for chacha_core. It accepts a 32-bit plaintext word stream over valid/ready, packs it into 512-bit blocks, and drives the core's init/next/key/iv/ctr/data_in. It captures data_out on data_out_valid and serializes the result as a 32-bit output stream. Partial final blocks are zero-padded, and only valid words are emitted.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT without core_data_out_valid before error (>=2)
TO_W, 16, width of timeout counter (2^TO_W > TIMEOUT_CYCLES)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin message, latch key_in/iv_in/ctr_in
key_in  in  256  message key
iv_in  in  64  message IV
ctr_in  in  64  starting block counter
s_word  in  32  input plaintext word
s_valid  in  1  input word valid
s_last  in  1  input word is last of message
s_ready  out  1  input word accepted when s_valid&s_ready
m_word  out  32  output ciphertext word
m_valid  out  1  output word valid
m_last  out  1  output word is last of message
m_ready  in  1  downstream accepts when m_valid&m_ready
core_init  out  1  one-cycle init pulse to chacha_core
core_next  out  1  one-cycle next pulse to chacha_core
core_key  out  256  latched key
core_iv  out  64  latched IV
core_ctr  out  64  latched ctr_in, constant for whole message
core_data_in  out  512  packed block, word 0 in [511:480]
core_ready  in  1  core idle
core_data_out  in  512  core result
core_data_out_valid  in  1  core result valid
busy  out  1  state != IDLE and != ERR
error  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, word count 0, first-block flag set, timeout counter 0, internal block/capture regs 0.
- States:
  - IDLE: start=1 latches key/iv/ctr, sets first=1, goes to FILL next cycle. s_ready=0, so a word presented in the same cycle as start is not taken.
  - FILL: s_ready=1. Each accepted word is written to slot wcnt (slot k at bits [511-32k -: 32]), then wcnt++. On acceptance with wcnt==15 or s_last=1: record nwords=wcnt+1 and last_msg=s_last, zero slots above wcnt, go to ISSUE.
  - ISSUE: s_ready=0. Wait while core_ready=0. When core_ready=1, assert exactly one of core_init (first=1) or core_next (first=0) for exactly one cycle, clear first, go to WAIT.
  - WAIT: timeout counter increments each cycle. On the first cycle with core_data_out_valid=1, capture core_data_out, clear the counter, go to DRAIN. If the counter reaches TIMEOUT_CYCLES, set error=1 and go to ERR.
  - DRAIN: m_valid=1, m_word = captured slot ocnt, m_last = last_msg & (ocnt==nwords-1). Advance ocnt only on m_ready. After the final word: if last_msg, go to IDLE; else wcnt=0 and go to FILL.
  - ERR: all handshakes 0, busy=0. start clears error and behaves as from IDLE. rst also clears error.
- The core deasserts data_out_valid in the cycle after init/next, so a stale valid is never seen in WAIT.
- start while busy=1 is ignored.
- m_word/m_last are held stable while m_valid&!m_ready.
- Latency: last input word accepted -> pulse no earlier than 1 cycle later. Capture -> first m_valid 1 cycle later.
- Core pulses are never both high. Neither is asserted outside ISSUE.
- Reset mid-operation returns to the reset state next cycle. Any in-flight core result is discarded.

Optional Feature:
CHACHA_STREAM_STATS_EN
- With the macro defined: adds outputs stat_blocks (32) and stat_cycles (32).
  - stat_blocks counts core pulses issued.
  - stat_cycles counts cycles spent in WAIT.
  - Both saturate at all-ones, and both are cleared by rst and by an accepted start.
- Without the macro: these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
1. Single block: start with key=0123456789abcdef x4, iv=deadbeefcafebabe, ctr=0, then 16 words of deadbeef with s_last on the 16th -> one core_init, no core_next, core_data_in={16{deadbeef}}; 16 m words equal to core_data_out MSW-first, m_last on the 16th; busy=0 afterwards.
2. Three blocks (48 words, word i = deadbeef^i) -> 1 init and 2 next pulses, core_ctr=0 throughout, 48 output words in order, m_last only on the 48th.
3. Partial block: 5 words, s_last on the 5th -> core_data_in slots 5..15 equal 0; exactly 5 output words, m_last on the 5th.
4. Backpressure: m_ready toggles 1,0,1,0 and core_ready is held low for 7 cycles in ISSUE -> no word lost or duplicated, s_ready=0 outside FILL, pulse issued on the first cycle core_ready=1.
5. Timeout with TIMEOUT_CYCLES=16 and a core that never asserts valid -> error=1 after 16 WAIT cycles, busy=0; a following start clears error and the message completes normally.
6. Reset asserted after 7 of 16 DRAIN words -> next cycle m_valid=0, busy=0, core pulses 0, error=0; the next message (test 1 stimulus) produces correct output.
